window_3x3_gen: RTL and testbench

Streaming 3x3 neighbourhood generator for RGB444 video, placed directly upstream of the median filter stage. Accepts one 12-bit pixel per valid cycle in raster order. Buffers the two previous lines in on-chip line RAM and a 3-column shift window. Presents the nine taps `PixelData_00..PixelData_22` plus a valid/border qualifier, registered, one cycle after each accepted pixel.

---
 rtl/window_3x3_gen.sv | 137 +++++++++++++
 tb/tb_window_3x3_gen.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/window_3x3_gen.sv
// window_3x3_gen: streaming 3x3 neighbourhood generator for RGB444 video.
// Two line RAMs hold rows y-1 and y-2. A two-column shift register holds
// columns x-1 and x-2. The nine taps are masked at the frame borders and
// then registered, so each accepted pixel gives a window one cycle later.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   i_valid, i_sof      pixel valid; start of frame (qualified by i_valid)
//   i_pixel[11:0]       pixel {R,G,B}, 4 bits each
//   o_valid             a window is presented this cycle
//   o_border            window contains forced-zero out-of-frame taps
//   o_x[8:0], o_y[7:0]  position of the window's bottom-right pixel
//   PixelData_rc        taps; r = 0 top (row y-2), c = 0 left (col x-2)
module window_3x3_gen #(
    parameter int unsigned H_ACT = 320,
    parameter int unsigned V_ACT = 240
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_valid,
    input  logic        i_sof,
    input  logic [11:0] i_pixel,
    output logic        o_valid,
    output logic        o_border,
    output logic [8:0]  o_x,
    output logic [7:0]  o_y,
    output logic [11:0] PixelData_00,
    output logic [11:0] PixelData_01,
    output logic [11:0] PixelData_02,
    output logic [11:0] PixelData_10,
    output logic [11:0] PixelData_11,
    output logic [11:0] PixelData_12,
    output logic [11:0] PixelData_20,
    output logic [11:0] PixelData_21,
    output logic [11:0] PixelData_22
);
    localparam int unsigned PW = 12;
    localparam int unsigned XW = 9;
    localparam int unsigned YW = 8;
    localparam int unsigned AW = (H_ACT > 1) ? $clog2(H_ACT) : 1;

    logic [XW-1:0] x_cnt, cur_x, x_nxt;
    logic [YW-1:0] y_cnt, cur_y, y_nxt;
    logic [AW-1:0] lb_addr;

    logic [PW-1:0] lb1 [H_ACT];
    logic [PW-1:0] lb2 [H_ACT];
    logic [PW-1:0] lb1_rd, lb2_rd;

    // Columns indexed [row]; row 0 is the oldest line (y-2).
    logic [2:0][PW-1:0] col1_q, col2_q, col_new;
    // Window sources indexed [col][row].
    logic [2:0][2:0][PW-1:0] src;
    // Taps indexed [row][col].
    logic [2:0][2:0][PW-1:0] tap_c, tap_q;

    logic [2:0] row_keep, col_keep;
    logic       border_c;

    // A qualified start-of-frame overrides whatever the counters hold.
    assign cur_x   = i_sof ? '0 : x_cnt;
    assign cur_y   = i_sof ? '0 : y_cnt;
    assign lb_addr = cur_x[AW-1:0];

    // Asynchronous read gives the pre-write value at the same address.
    assign lb1_rd  = lb1[lb_addr];
    assign lb2_rd  = lb2[lb_addr];
    assign col_new = {i_pixel, lb1_rd, lb2_rd};
    assign src     = {col_new, col2_q, col1_q};

    // Rows/columns that would come from before the frame start are zeroed.
    assign row_keep = {1'b1, cur_y >= YW'(1), cur_y >= YW'(2)};
    assign col_keep = {1'b1, cur_x >= XW'(1), cur_x >= XW'(2)};
    assign border_c = (cur_x < XW'(2)) || (cur_y < YW'(2));

    for (genvar r = 0; r < 3; r++) begin : g_row
        for (genvar c = 0; c < 3; c++) begin : g_col
            assign tap_c[r][c] = (row_keep[r] && col_keep[c]) ? src[c][r] : '0;
        end
    end

    // Raster position advance with line and frame wrap.
    always_comb begin
        x_nxt = cur_x + XW'(1);
        y_nxt = cur_y;
        if (cur_x == XW'(H_ACT - 1)) begin
            x_nxt = '0;
            y_nxt = (cur_y == YW'(V_ACT - 1)) ? '0 : cur_y + YW'(1);
        end
    end

    // Line buffers: not reset, border masking hides stale content.
    always_ff @(posedge clk) begin
        if (i_valid) begin
            lb1[lb_addr] <= i_pixel;
            lb2[lb_addr] <= lb1_rd;
        end
    end

    // Counters, column shift and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_cnt    <= '0;
            y_cnt    <= '0;
            col1_q   <= '0;
            col2_q   <= '0;
            o_valid  <= 1'b0;
            o_border <= 1'b0;
            o_x      <= '0;
            o_y      <= '0;
            tap_q    <= '0;
        end else begin
            o_valid <= i_valid;
            if (i_valid) begin
                x_cnt    <= x_nxt;
                y_cnt    <= y_nxt;
                col1_q   <= col2_q;
                col2_q   <= col_new;
                o_border <= border_c;
                o_x      <= cur_x;
                o_y      <= cur_y;
                tap_q    <= tap_c;
            end
        end
    end

    assign PixelData_00 = tap_q[0][0];
    assign PixelData_01 = tap_q[0][1];
    assign PixelData_02 = tap_q[0][2];
    assign PixelData_10 = tap_q[1][0];
    assign PixelData_11 = tap_q[1][1];
    assign PixelData_12 = tap_q[1][2];
    assign PixelData_20 = tap_q[2][0];
    assign PixelData_21 = tap_q[2][1];
    assign PixelData_22 = tap_q[2][2];

endmodule

// File: tb/tb_window_3x3_gen.sv
// Testbench for window_3x3_gen with a 4x4 frame. A position/frame-array
// reference model predicts every output cycle; a table of hand-derived
// ramp-frame windows and a few directed sequences cover the corner cases.
module tb_window_3x3_gen;
    localparam int unsigned H = 4;
    localparam int unsigned V = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_valid;
    logic        i_sof;
    logic [11:0] i_pixel;
    logic        o_valid, o_border;
    logic [8:0]  o_x;
    logic [7:0]  o_y;
    logic [11:0] p00, p01, p02, p10, p11, p12, p20, p21, p22;

    always #5 clk = ~clk;

    window_3x3_gen #(.H_ACT(H), .V_ACT(V)) dut (
        .clk(clk), .reset_n(reset_n), .i_valid(i_valid), .i_sof(i_sof),
        .i_pixel(i_pixel), .o_valid(o_valid), .o_border(o_border),
        .o_x(o_x), .o_y(o_y),
        .PixelData_00(p00), .PixelData_01(p01), .PixelData_02(p02),
        .PixelData_10(p10), .PixelData_11(p11), .PixelData_12(p12),
        .PixelData_20(p20), .PixelData_21(p21), .PixelData_22(p22)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          mx, my;
    logic [11:0] img [V][H];
    logic        e_valid, e_border;
    int          e_x, e_y;
    logic [11:0] e_tap [3][3];

    typedef struct {
        int          x;
        int          y;
        logic        border;
        logic [11:0] t00, t11, t22, t20;
    } vec_t;
    vec_t vecs [6];

    typedef struct {
        int          x;
        int          y;
        logic        border;
        logic [11:0] t [9];
    } win_t;
    win_t rec [H*V];
    int   rec_n;
    int   cmp_n;

    bit ramp_mode;
    bit rec_mode;
    bit cmp_mode;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] dut_tap(input int k);
        case (k)
            0: return p00;
            1: return p01;
            2: return p02;
            3: return p10;
            4: return p11;
            5: return p12;
            6: return p20;
            7: return p21;
            default: return p22;
        endcase
    endfunction

    task automatic model_reset();
        mx = 0; my = 0;
        e_valid = 1'b0; e_border = 1'b0; e_x = 0; e_y = 0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) e_tap[r][c] = '0;
    endtask

    // Window = the frame pixels at (x-2..x, y-2..y); anything left of or
    // above the frame origin is zero.
    task automatic model_accept(input logic [11:0] p, input logic s);
        int px, py, sx, sy;
        px = s ? 0 : mx;
        py = s ? 0 : my;
        img[py][px] = p;
        e_valid  = 1'b1;
        e_x      = px;
        e_y      = py;
        e_border = (px < 2) || (py < 2);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                sx = px - 2 + c;
                sy = py - 2 + r;
                e_tap[r][c] = (sx >= 0 && sy >= 0) ? img[sy][sx] : 12'h000;
            end
        mx = px + 1;
        my = py;
        if (mx == H) begin
            mx = 0;
            my = (py + 1 == V) ? 0 : py + 1;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".o_valid"},  32'(o_valid),  32'(e_valid));
        chk({tag, ".o_border"}, 32'(o_border), 32'(e_border));
        chk({tag, ".o_x"},      32'(o_x),      32'(e_x));
        chk({tag, ".o_y"},      32'(o_y),      32'(e_y));
        for (int k = 0; k < 9; k++)
            chk($sformatf("%s.tap%0d%0d", tag, k / 3, k % 3),
                32'(dut_tap(k)), 32'(e_tap[k / 3][k % 3]));
    endtask

    task automatic step(input logic v, input logic s, input logic [11:0] p);
        i_valid = v;
        i_sof   = s;
        i_pixel = p;
        @(posedge clk);
        #1;
        if (!reset_n)  model_reset();
        else if (v)    model_accept(p, s);
        else           e_valid = 1'b0;
        check_all("win");
        if (ramp_mode && reset_n && v) begin
            for (int i = 0; i < 6; i++) begin
                if (vecs[i].x == e_x && vecs[i].y == e_y) begin
                    chk($sformatf("vec%0d.border", i), 32'(o_border), 32'(vecs[i].border));
                    chk($sformatf("vec%0d.t00", i), 32'(p00), 32'(vecs[i].t00));
                    chk($sformatf("vec%0d.t11", i), 32'(p11), 32'(vecs[i].t11));
                    chk($sformatf("vec%0d.t22", i), 32'(p22), 32'(vecs[i].t22));
                    chk($sformatf("vec%0d.t20", i), 32'(p20), 32'(vecs[i].t20));
                end
            end
        end
        if (rec_mode && reset_n && v && rec_n < H*V) begin
            rec[rec_n].x = e_x;
            rec[rec_n].y = e_y;
            rec[rec_n].border = e_border;
            for (int k = 0; k < 9; k++) rec[rec_n].t[k] = e_tap[k / 3][k % 3];
            rec_n++;
        end
        if (cmp_mode && o_valid && cmp_n < H*V) begin
            chk("bub.x", 32'(o_x), 32'(rec[cmp_n].x));
            chk("bub.y", 32'(o_y), 32'(rec[cmp_n].y));
            chk("bub.border", 32'(o_border), 32'(rec[cmp_n].border));
            for (int k = 0; k < 9; k++)
                chk($sformatf("bub.tap%0d", k), 32'(dut_tap(k)), 32'(rec[cmp_n].t[k]));
            cmp_n++;
        end
    endtask

    task automatic ramp_frame(input bit sof, input int max_gap);
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++) begin
                if (max_gap > 0) begin
                    int g;
                    g = $urandom_range(max_gap, 0);
                    for (int j = 0; j < g; j++) step(1'b0, 1'b0, 12'($urandom));
                end
                step(1'b1, sof && x == 0 && y == 0, {4'h0, 4'(y), 4'(x)});
            end
    endtask

    initial begin
        vecs[0] = '{x: 3, y: 2, border: 1'b0, t00: 12'h001, t11: 12'h012, t22: 12'h023, t20: 12'h021};
        vecs[1] = '{x: 1, y: 1, border: 1'b1, t00: 12'h000, t11: 12'h000, t22: 12'h011, t20: 12'h000};
        vecs[2] = '{x: 0, y: 0, border: 1'b1, t00: 12'h000, t11: 12'h000, t22: 12'h000, t20: 12'h000};
        vecs[3] = '{x: 2, y: 2, border: 1'b0, t00: 12'h000, t11: 12'h011, t22: 12'h022, t20: 12'h020};
        vecs[4] = '{x: 3, y: 3, border: 1'b0, t00: 12'h011, t11: 12'h022, t22: 12'h033, t20: 12'h031};
        vecs[5] = '{x: 0, y: 3, border: 1'b1, t00: 12'h000, t11: 12'h000, t22: 12'h030, t20: 12'h000};
        ramp_mode = 1'b0; rec_mode = 1'b0; cmp_mode = 1'b0;
        rec_n = 0; cmp_n = 0;
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++) img[y][x] = '0;
        model_reset();

        // Reset held with valid input: everything stays zero.
        reset_n = 1'b0; i_valid = 1'b1; i_sof = 1'b0; i_pixel = 12'hABC;
        #1;
        check_all("rst0");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 12'hABC);
        reset_n = 1'b1;

        // First frame after reset without sof, then a recorded sof frame.
        ramp_mode = 1'b1;
        ramp_frame(1'b0, 0);
        rec_mode = 1'b1;
        ramp_frame(1'b1, 0);
        rec_mode = 1'b0;

        // Same frame with bubbles must produce the identical window sequence.
        cmp_mode = 1'b1;
        ramp_frame(1'b1, 5);
        cmp_mode = 1'b0;
        chk("bub.count", 32'(cmp_n), 32'(H*V));
        ramp_mode = 1'b0;

        // Mid-frame resync at counter position (2,1).
        for (int k = 0; k < H + 2; k++)
            step(1'b1, k == 0, {4'h0, 4'(k / H), 4'(k % H)});
        step(1'b1, 1'b1, 12'h5A5);
        chk("resync.x", 32'(o_x), 32'd0);
        chk("resync.y", 32'(o_y), 32'd0);
        chk("resync.border", 32'(o_border), 32'd1);
        step(1'b1, 1'b0, 12'h3C3);
        chk("resync.next_x", 32'(o_x), 32'd1);
        step(1'b0, 1'b0, 12'h000);

        // Async reset between edges after pixel (2,2).
        ramp_mode = 1'b1;
        for (int k = 0; k < 2*H + 3; k++)
            step(1'b1, k == 0, {4'h0, 4'(k / H), 4'(k % H)});
        chk("pre_rst.x", 32'(o_x), 32'd2);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        step(1'b1, 1'b0, 12'h777);
        step(1'b0, 1'b0, 12'h000);
        reset_n = 1'b1;
        ramp_frame(1'b0, 0);
        ramp_frame(1'b1, 0);
        ramp_mode = 1'b0;

        // Random pixels, random bubbles, occasional mid-frame sof.
        for (int n = 0; n < 5 * H * V; n++) begin
            if ($urandom_range(3, 0) == 0) step(1'b0, 1'($urandom), 12'($urandom));
            step(1'b1, $urandom_range(19, 0) == 0, 12'($urandom));
        end
        step(1'b0, 1'b0, 12'h000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
